// File: rtl/lcd_msg_sequencer.sv
// lcd_msg_sequencer: turns coffee-controller status into LCD display messages.
// Active errors rotate on a dwell timer; a message (id + 16-cell progress bar)
// is offered over valid/ready only when the displayed content changes.
module lcd_msg_sequencer #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned SPEEDUP_DIV = 1,
    parameter int unsigned DWELL_MS    = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] err_mask,
    input  logic [1:0]  sys_state,
    input  logic [2:0]  brew_phase,
    input  logic [4:0]  brew_progress16,
    input  logic        msg_ready,
    output logic        msg_valid,
    output logic [4:0]  msg_id,
    output logic [15:0] msg_bar
);

    // Dwell length in clock ticks; clamped to 1 so the rotator always advances.
    localparam longint unsigned TICKS_RAW =
        (longint'(CLK_HZ) / longint'(SPEEDUP_DIV) / 64'd1000) * longint'(DWELL_MS);
    localparam logic [31:0] DWELL_TICKS = (TICKS_RAW == 64'd0) ? 32'd1 : 32'(TICKS_RAW);

    typedef struct packed {
        logic [4:0]  id;
        logic [15:0] bar;
    } msg_t;

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_t;

    // Lowest set bit of the mask (0 when the mask is empty).
    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Next set bit strictly above cur, wrapping to the lowest set bit.
    function automatic logic [3:0] next_set(input logic [15:0] m, input logic [3:0] cur);
        logic [3:0] r;
        logic       found;
        r     = lowest_set(m);
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!found && (i > int'(cur)) && m[i]) begin
                r     = 4'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Error rotator state
    logic        err_active_q, err_active_d;
    logic [3:0]  err_idx_q,    err_idx_d;
    logic [31:0] dwell_cnt_q,  dwell_cnt_d;

    // Output / handshake state
    state_t      state_q,      state_d;
    msg_t        out_q,        out_d;
    msg_t        last_sent_q,  last_sent_d;
    logic        sent_once_q,  sent_once_d;

    msg_t        desired;
    logic [4:0]  prog_sat;

    // Rotator next-state: entry, forced advance on a cleared bit, or dwell expiry.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        err_active_d = err_active_q;
        err_idx_d    = err_idx_q;
        dwell_cnt_d  = dwell_cnt_q + 32'd1;
        if (err_mask == 16'h0000) begin
            err_active_d = 1'b0;
            dwell_cnt_d  = 32'd0;
        end else if (!err_active_q) begin
            err_active_d = 1'b1;
            err_idx_d    = lowest_set(err_mask);
            dwell_cnt_d  = 32'd0;
        end else if (!err_mask[err_idx_q] || (dwell_cnt_q == DWELL_TICKS - 32'd1)) begin
            err_idx_d    = next_set(err_mask, err_idx_q);
            dwell_cnt_d  = 32'd0;
        end
    end

    // Desired message from the registered error view and the live status inputs.
    always_comb begin
        prog_sat    = (brew_progress16 > 5'd16) ? 5'd16 : brew_progress16;
        desired.id  = 5'd0;
        desired.bar = 16'h0000;
        if (err_active_q) begin
            desired.id = {1'b1, err_idx_q};
        end else if (sys_state == 2'd1) begin
            desired.id = 5'd1;
        end else if (sys_state == 2'd2) begin
            desired.id = (brew_phase > 3'd4) ? 5'd7 : ({2'b00, brew_phase} + 5'd2);
            for (int i = 0; i < 16; i++) begin
                desired.bar[i] = (5'(i) < prog_sat);
            end
        end
    end

    // Handshake FSM: load when idle and content differs, hold while stalled.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        last_sent_d = last_sent_q;
        sent_once_d = sent_once_q;
        case (state_q)
            ST_IDLE: begin
                if (!sent_once_q || (desired != last_sent_q)) begin
                    out_d   = desired;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (msg_ready) begin
                    last_sent_d = out_q;
                    sent_once_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            err_active_q <= 1'b0;
            err_idx_q    <= 4'd0;
            dwell_cnt_q  <= 32'd0;
            state_q      <= ST_IDLE;
            out_q        <= '0;
            last_sent_q  <= '0;
            sent_once_q  <= 1'b0;
        end else begin
            err_active_q <= err_active_d;
            err_idx_q    <= err_idx_d;
            dwell_cnt_q  <= dwell_cnt_d;
            state_q      <= state_d;
            out_q        <= out_d;
            last_sent_q  <= last_sent_d;
            sent_once_q  <= sent_once_d;
        end
    end

    assign msg_valid = (state_q == ST_PEND);
    assign msg_id    = out_q.id;
    assign msg_bar   = out_q.bar;

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Directed self-checking bench for lcd_msg_sequencer (DWELL_TICKS = 8).
module tb_lcd_msg_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] err_mask = 16'h0000;
    logic [1:0]  sys_state = 2'd0;
    logic [2:0]  brew_phase = 3'd0;
    logic [4:0]  brew_progress16 = 5'd0;
    logic        msg_ready = 1'b1;
    logic        msg_valid;
    logic [4:0]  msg_id;
    logic [15:0] msg_bar;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // 50 MHz / 6250 / 1000 * 1 ms = 8 ticks per dwell
    lcd_msg_sequencer #(
        .CLK_HZ(50_000_000),
        .SPEEDUP_DIV(6250),
        .DWELL_MS(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .err_mask(err_mask),
        .sys_state(sys_state),
        .brew_phase(brew_phase),
        .brew_progress16(brew_progress16),
        .msg_ready(msg_ready),
        .msg_valid(msg_valid),
        .msg_id(msg_id),
        .msg_bar(msg_bar)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Wait (bounded) for msg_valid, check content, record latency and cycle stamp.
    // When ready is high the message is consumed by stepping one more cycle.
    task automatic get_msg(input string tag, input logic [4:0] eid, input logic [15:0] ebar,
                           output int lat, output int stamp);
        lat = 0;
        while (!msg_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid"}, 32'(msg_valid), 32'd1);
        check({tag, "_id"}, 32'(msg_id), 32'(eid));
        check({tag, "_bar"}, 32'(msg_bar), 32'(ebar));
        stamp = cyc;
        if (msg_ready) @(negedge clk);
    endtask

    // Count cycles with msg_valid high over a window; none are expected.
    task automatic quiet(input string tag, input int n);
        int hits;
        hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (msg_valid) hits++;
        end
        check(tag, 32'(hits), 32'd0);
    endtask

    initial begin
        int lat, t1, t2, t3, t4, held;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(msg_valid), 32'd0);
        check("rst_id", 32'(msg_id), 32'd0);
        check("rst_bar", 32'(msg_bar), 32'd0);

        // First transfer after release: SELECT, id 0, one cycle later
        rst = 1'b0;
        get_msg("boot", 5'd0, 16'h0000, lat, t1);
        check("boot_lat", 32'(lat), 32'd1);
        quiet("boot_quiet", 10);

        // Brew phase 3, thermometer bar
        sys_state = 2'd2; brew_phase = 3'd3; brew_progress16 = 5'd4;
        get_msg("brew4", 5'd5, 16'h000F, lat, t1);
        check("brew4_lat", 32'(lat), 32'd1);
        brew_progress16 = 5'd5;
        get_msg("brew5", 5'd5, 16'h001F, lat, t1);
        brew_progress16 = 5'd20;
        get_msg("brew20", 5'd5, 16'hFFFF, lat, t1);
        quiet("brew_quiet", 5);

        // WAIT, DONE (phase 6) and state 3 as SELECT
        sys_state = 2'd1;
        get_msg("wait", 5'd1, 16'h0000, lat, t1);
        sys_state = 2'd2; brew_phase = 3'd6; brew_progress16 = 5'd16;
        get_msg("done", 5'd7, 16'hFFFF, lat, t1);
        sys_state = 2'd3;
        get_msg("state3", 5'd0, 16'h0000, lat, t1);

        // Two-error rotation, 8-cycle spacing
        err_mask = 16'h0104;
        get_msg("err_a", 5'd18, 16'h0000, lat, t1);
        check("err_entry_lat", 32'(lat), 32'd2);
        get_msg("err_b", 5'd24, 16'h0000, lat, t2);
        check("err_gap1", 32'(t2 - t1), 32'd8);
        get_msg("err_c", 5'd18, 16'h0000, lat, t3);
        check("err_gap2", 32'(t3 - t2), 32'd8);
        get_msg("err_d", 5'd24, 16'h0000, lat, t4);
        check("err_gap3", 32'(t4 - t3), 32'd8);

        // Clear the displayed bit 8 mid-dwell: jump straight back to 18
        repeat (3) @(negedge clk);
        err_mask = 16'h0004;
        get_msg("err_clr", 5'd18, 16'h0000, lat, t1);
        check("err_clr_lat", 32'(lat), 32'd2);
        quiet("single2_quiet", 30);

        // Single bit 6 for 40 dwells: one transfer only
        err_mask = 16'h0040;
        get_msg("err6", 5'd22, 16'h0000, lat, t1);
        quiet("single6_quiet", 320);
        err_mask = 16'h0000;
        get_msg("err_exit", 5'd0, 16'h0000, lat, t1);
        check("err_exit_lat", 32'(lat), 32'd2);
        quiet("exit_quiet", 10);

        // Stall: id 3 held while phase steps to 2
        msg_ready = 1'b0;
        sys_state = 2'd2; brew_phase = 3'd1; brew_progress16 = 5'd0;
        get_msg("stall", 5'd3, 16'h0000, lat, t1);
        brew_phase = 3'd2;
        held = 0;
        repeat (10) begin
            @(negedge clk);
            if (msg_valid && msg_id == 5'd3 && msg_bar == 16'h0000) held++;
        end
        check("stall_held", 32'(held), 32'd10);
        msg_ready = 1'b1;
        @(negedge clk);
        msg_ready = 1'b0;
        check("bubble_valid", 32'(msg_valid), 32'd0);
        @(negedge clk);
        check("after_bubble_valid", 32'(msg_valid), 32'd1);
        check("after_bubble_id", 32'(msg_id), 32'd4);

        // Reset while stalled drops the message; fresh transfer afterwards
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(msg_valid), 32'd0);
        check("midrst_id", 32'(msg_id), 32'd0);
        rst = 1'b0;
        msg_ready = 1'b1;
        get_msg("post_rst", 5'd4, 16'h0000, lat, t1);
        check("post_rst_lat", 32'(lat), 32'd1);
        quiet("post_rst_quiet", 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_msg_sequencer.md
# lcd_msg_sequencer

Downstream consumer of the coffee controller's status outputs (`err_mask`, `sys_state`, `brew_phase`, `brew_progress16`). It turns them into a stream of display messages for the LCD writer, rotating through active errors on a fixed dwell timer. Each message is a message ID plus a 16-cell progress-bar pattern, handed off over a valid/ready handshake. A message is sent only when the displayed content changes.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency.
- `SPEEDUP_DIV`, 1, divides the tick rate for simulation (>1 speeds up).
- `DWELL_MS`, 1500, time each error is shown before rotating.
- One clock; reset is synchronous and active-high. Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `err_mask`  in  16  active error bits, bit k = error k.
- `sys_state`  in  2  0=SELECT, 1=WAIT, 2=BREW; 3 is treated as SELECT.
- `brew_phase`  in  3  0..4 = brew steps, 5 = DONE; 6..7 are treated as DONE.
- `brew_progress16`  in  5  0..16; values above 16 saturate to 16.
- `msg_ready`  in  1  LCD writer accepts the message.
- `msg_valid`  out  1  message pending.
- `msg_id`  out  5  message code.
- `msg_bar`  out  16  thermometer progress pattern.

## Operation
- Desired message, evaluated every cycle:
  - If `err_active`: `msg_id` = 16 + `err_idx`, bar = 0.
  - Else if `sys_state` = 1: `msg_id` = 1, bar = 0.
  - Else if `sys_state` = 2: `msg_id` = 2 + `brew_phase` (phases 0..4 give 2..6; DONE gives 7), bar = thermometer.
  - Else: `msg_id` = 0, bar = 0.
- Thermometer rule: `msg_bar[i]` = 1 iff i < min(`brew_progress16`, 16). So 0 gives 16'h0000, 4 gives 16'h000F, and 16 or more gives 16'hFFFF.
- Error rotator registers: `err_active`, `err_idx[3:0]`, and a 32-bit dwell counter.
  - `DWELL_TICKS` = (`CLK_HZ`/`SPEEDUP_DIV`/1000)·`DWELL_MS`, minimum 1.
  - `err_mask` == 0: `err_active` ← 0 and the counter clears.
  - Entry (`err_active` = 0 and mask ≠ 0): `err_idx` ← lowest set bit, `err_active` ← 1, counter clears.
  - Current bit cleared while the mask is still nonzero: `err_idx` ← next set bit strictly above `err_idx`, wrapping to the lowest; counter clears.
  - Counter == `DWELL_TICKS`−1: same advance rule, counter clears. Otherwise the counter increments.
  - With a single set bit, the advance re-selects the same index, so no new message is produced.
- Output register and handshake:
  - A `last_sent` register (id + bar) and a `sent_once` flag track what has been accepted.
  - When `msg_valid` = 0 and (`sent_once` = 0 or desired ≠ `last_sent`): load `msg_id`/`msg_bar` with the desired message and set `msg_valid`.
  - While `msg_valid` = 1 and `msg_ready` = 0: `msg_id` and `msg_bar` are held stable, even if the desired message changes.
  - On `msg_valid` & `msg_ready`: `last_sent` ← outputs, `sent_once` ← 1, `msg_valid` ← 0. A new load may occur on the next cycle. The bubble cycle is mandatory.
  - Intermediate desired values that come and go while a message is stalled are dropped. Only the desired value at load time is sent.

## Timing
- Reset values: `msg_valid` = 0, `msg_id` = 0, `msg_bar` = 0, `err_active` = 0, `err_idx` = 0, counter = 0, `sent_once` = 0, `last_sent` = 0.
- First cycle after reset release: `msg_valid` rises at the next edge with `msg_id` = 0 (given SELECT and no errors).
- Non-error input change: `msg_valid` rises 1 cycle later, provided it was idle.
- Error entry: `err_idx` registered at edge 1, `msg_valid` with `msg_id` = 16+k at edge 2.
- Rotation period: exactly `DWELL_TICKS` cycles between `err_idx` updates while the mask is stable.
- Reset mid-handshake drops the pending message. Behaviour afterwards is as after power-up.

## Test plan
- Reset release, `sys_state`=0, mask=0, ready=1 → one transfer, `msg_id`=0, bar=0, then `msg_valid` stays 0.
- `sys_state`=2, phase=3, progress 4→5 with ready=1 → transfers `msg_id`=5 with bar 16'h000F, then 16'h001F. Progress=20 → 16'hFFFF.
- mask=16'h0104, `SPEEDUP_DIV` set so `DWELL_TICKS`=8 → ids 18, 24, 18, … with updates spaced exactly 8 cycles. Clearing bit 8 mid-dwell → id 18 on the next load.
- Single error bit 6 held for 40 dwell periods → exactly one transfer of id 22. Mask→0 → one transfer of the state message.
- ready=0 for 10 cycles while phase steps 1→2 → `msg_id`/`msg_bar` held at 3. After the ready pulse, bubble cycle, then id 4.
- Assert `rst` with `msg_valid`=1 stalled → next cycle `msg_valid`=0. After release, a fresh transfer of the current state message.
